// File: rtl/dot_mx_pkg.sv
// Shared types and helpers for the MX block-scale accumulator.
//   E8M0_BIAS / E8M0_NAN : shared-scale encoding constants
//   s1_t / s2_t          : pipeline stage payloads (block sum / scaled term)
//   sat_add              : signed add clamped to the accumulator range
package dot_mx_pkg;

    localparam int IN_W    = 43;   // block-sum width at default element format
    localparam int ACC_W   = 64;   // accumulator width
    localparam int SHIFT_W = 11;   // signed combined-scale shift amount

    localparam int         E8M0_BIAS = 127;
    localparam logic [7:0] E8M0_NAN  = 8'hFF;

    typedef struct packed {
        logic signed [IN_W-1:0]    dp;
        logic signed [SHIFT_W-1:0] lsh;
        logic                      nan;
        logic                      last;
    } s1_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] term;
        logic                    nan;
        logic                    ovf;
        logic                    last;
    } s2_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] sum;
        logic                    ovf;
    } sat_t;

    // One guard bit catches overflow; the clamp targets -2^(W-1) and 2^(W-1)-1.
    function automatic sat_t sat_add(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        sat_t                  r;
        s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.ovf = s[ACC_W] ^ s[ACC_W-1];
        if (r.ovf)
            r.sum = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            r.sum = s[ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/dot_mx_accum_shift.sv
// Combinational bidirectional clamped shifter for applying a power-of-two
// scale to a signed block sum.
//   dp   : signed block sum
//   lsh  : signed shift amount (positive = left)
//   term : scaled value, saturated to the acc_width range on overflow
//   ovf  : left shift lost significant bits / left the signed range
module mx_scale_shift #(
    parameter int in_width    = 43,
    parameter int acc_width   = 64,
    parameter int shift_width = 11
) (
    input  logic signed [in_width-1:0]    dp,
    input  logic signed [shift_width-1:0] lsh,
    output logic signed [acc_width-1:0]   term,
    output logic                          ovf
);

    localparam int WIDE = in_width + acc_width;

    logic signed [WIDE-1:0]      wide;
    logic signed [acc_width-1:0] ext;
    logic [shift_width-1:0]      mag;

    always_comb begin
        wide = '0;
        ext  = '0;
        mag  = '0;
        term = '0;
        ovf  = 1'b0;
        if (!lsh[shift_width-1]) begin
            // Left: clamp at acc_width; the wide field holds any dp << acc_width
            // exactly, so the upper bits tell us whether the result fits.
            mag = lsh;
            if (mag > shift_width'(acc_width))
                mag = shift_width'(acc_width);
            wide = {{acc_width{dp[in_width-1]}}, dp};
            wide = wide << mag;
            ovf  = (wide[WIDE-1:acc_width-1] != '0) && (wide[WIDE-1:acc_width-1] != '1);
            if (ovf)
                term = dp[in_width-1] ? {1'b1, {(acc_width-1){1'b0}}}
                                      : {1'b0, {(acc_width-1){1'b1}}};
            else
                term = wide[acc_width-1:0];
        end else begin
            // Right: arithmetic shift floors, so tiny negatives settle at -1.
            mag = -lsh;
            if (mag > shift_width'(in_width))
                mag = shift_width'(in_width);
            ext  = {{(acc_width-in_width){dp[in_width-1]}}, dp};
            term = ext >>> mag;
        end
    end

endmodule

// File: rtl/dot_mx_accum.sv
// MX block-scale accumulator: applies the two E8M0 shared scales to each
// fixed-point block sum and accumulates the blocks of one vector.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_valid/o_ready           : block beat handshake
//   i_dp, i_nan               : block sum and special-value flag
//   i_scale_a, i_scale_b      : E8M0 block scales
//   i_last                    : final block of the vector
//   o_valid/i_ready           : result handshake
//   o_acc, o_nan, o_ovf       : result and sticky flags for the vector
module dot_mx_accum
    import dot_mx_pkg::*;
#(
    parameter int exp_width   = 4,
    parameter int man_width   = 3,
    parameter int k           = 32,
    parameter int in_width    = 2*((1<<exp_width)+man_width)+$clog2(k),
    parameter int scale_width = 8,
    parameter int acc_frac    = 16,
    parameter int acc_width   = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [in_width-1:0]  i_dp,
    input  logic                        i_nan,
    input  logic [scale_width-1:0]      i_scale_a,
    input  logic [scale_width-1:0]      i_scale_b,
    input  logic                        i_last,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_acc,
    output logic                        o_nan,
    output logic                        o_ovf
);

    logic                        en;
    logic signed [SHIFT_W-1:0]   lsh;
    s1_t                         s1;
    logic                        s1_valid;
    s2_t                         s2;
    logic                        s2_valid;
    logic signed [acc_width-1:0] sh_term;
    logic                        sh_ovf;
    logic signed [acc_width-1:0] acc;
    logic                        nan_st;
    logic                        ovf_st;
    sat_t                        sat;
    logic                        fin_nan;
    logic                        fin_ovf;

    // The whole pipeline freezes only while a finished result is refused.
    assign en      = !(o_valid && !i_ready);
    assign o_ready = en;

    assign lsh = SHIFT_W'(i_scale_a) + SHIFT_W'(i_scale_b)
               - SHIFT_W'(2*E8M0_BIAS) + SHIFT_W'(acc_frac);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1.dp   <= i_dp;
                s1.lsh  <= lsh;
                s1.nan  <= i_nan || (i_scale_a == E8M0_NAN) || (i_scale_b == E8M0_NAN);
                s1.last <= i_last;
            end
        end
    end

    mx_scale_shift #(
        .in_width    (in_width),
        .acc_width   (acc_width),
        .shift_width (SHIFT_W)
    ) u_shift (
        .dp   (s1.dp),
        .lsh  (s1.lsh),
        .term (sh_term),
        .ovf  (sh_ovf)
    );

    // A NaN beat adds nothing; its shift result is meaningless, so its
    // overflow is dropped too.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2.term  <= s1.nan ? '0 : sh_term;
            s2.ovf   <= !s1.nan && sh_ovf;
            s2.nan   <= s1.nan;
            s2.last  <= s1.last;
        end
    end

    always_comb begin
        sat     = sat_add(acc, s2.term);
        fin_nan = nan_st || s2.nan;
        fin_ovf = ovf_st || s2.ovf || sat.ovf;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            nan_st  <= 1'b0;
            ovf_st  <= 1'b0;
            o_valid <= 1'b0;
            o_acc   <= '0;
            o_nan   <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (en) begin
            // With en high any pending result is being taken this cycle.
            o_valid <= s2_valid && s2.last;
            if (s2_valid) begin
                if (s2.last) begin
                    o_acc  <= sat.sum;
                    o_nan  <= fin_nan;
                    o_ovf  <= fin_ovf;
                    acc    <= '0;
                    nan_st <= 1'b0;
                    ovf_st <= 1'b0;
                end else begin
                    acc    <= sat.sum;
                    nan_st <= fin_nan;
                    ovf_st <= fin_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_mx_accum.sv
module tb_dot_mx_accum;

    typedef struct {
        logic signed [63:0] acc;
        logic               nan;
        logic               ovf;
    } exp_t;

    localparam logic signed [42:0] DP_MAX = 43'h3FFFFFFFFFF;
    localparam logic signed [42:0] DP_MIN = 43'h40000000000;
    localparam logic signed [63:0] ACC_MAX = 64'h7FFFFFFFFFFFFFFF;
    localparam logic signed [63:0] ACC_MIN = 64'h8000000000000000;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic signed [42:0] i_dp;
    logic               i_nan;
    logic [7:0]         i_scale_a;
    logic [7:0]         i_scale_b;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic signed [63:0] o_acc;
    logic               o_nan;
    logic               o_ovf;

    exp_t q[$];
    int   n_checks;
    int   n_errors;

    dot_mx_accum dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_dp      (i_dp),
        .i_nan     (i_nan),
        .i_scale_a (i_scale_a),
        .i_scale_b (i_scale_b),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_acc     (o_acc),
        .o_nan     (o_nan),
        .o_ovf     (o_ovf)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Drive one beat; when it closes a vector and push is set, queue the result.
    task automatic beat(input logic signed [42:0] dp, input logic nan,
                        input logic [7:0] sa, input logic [7:0] sb, input logic last,
                        input logic push, input logic signed [63:0] eacc,
                        input logic enan, input logic eovf);
        int   n;
        logic took;
        exp_t e;
        i_valid   = 1'b1;
        i_dp      = dp;
        i_nan     = nan;
        i_scale_a = sa;
        i_scale_b = sb;
        i_last    = last;
        if (last && push) begin
            e.acc = eacc; e.nan = enan; e.ovf = eovf;
            q.push_back(e);
        end
        n    = 0;
        took = 1'b0;
        while (!took && n < 100) begin
            @(negedge i_clk);
            took = o_ready;
            @(posedge i_clk);
            n++;
        end
        if (!took) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_accept: got no o_ready in %0d cycles expected acceptance", n);
        end
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_nan   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d results pending expected 0", q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_dp      = '0;
        i_nan     = 1'b0;
        i_scale_a = '0;
        i_scale_b = '0;
        i_last    = 1'b0;
        i_ready   = 1'b1;
        fork
            begin : monitor
                logic               stall_prev;
                logic signed [63:0] prev_acc;
                logic               prev_nan;
                logic               prev_ovf;
                exp_t               e;
                stall_prev = 1'b0;
                prev_acc   = '0;
                prev_nan   = 1'b0;
                prev_ovf   = 1'b0;
                forever begin
                    @(negedge i_clk);
                    if (!i_rst_n) begin
                        stall_prev = 1'b0;
                    end else begin
                        if (stall_prev)
                            chk("hold_stable", {o_acc[61:0], o_nan, o_ovf},
                                {prev_acc[61:0], prev_nan, prev_ovf});
                        if (o_valid && !i_ready)
                            chk("stall_o_ready", 64'(o_ready), 64'd0);
                        if (o_valid && i_ready) begin
                            n_checks++;
                            if (q.size() == 0) begin
                                n_errors++;
                                $display("FAIL result_extra: got acc=%0d with empty scoreboard expected none", o_acc);
                            end else begin
                                e = q.pop_front();
                                if (o_acc !== e.acc || o_nan !== e.nan || o_ovf !== e.ovf) begin
                                    n_errors++;
                                    $display("FAIL result: got acc=%0d nan=%0b ovf=%0b expected acc=%0d nan=%0b ovf=%0b",
                                             o_acc, o_nan, o_ovf, e.acc, e.nan, e.ovf);
                                end
                            end
                        end
                        stall_prev = o_valid && !i_ready;
                        prev_acc   = o_acc;
                        prev_nan   = o_nan;
                        prev_ovf   = o_ovf;
                    end
                end
            end
            begin : stimulus
                int n;
                #2;
                chk("rst_o_valid", 64'(o_valid), 64'd0);
                chk("rst_o_acc", o_acc, 64'd0);
                chk("rst_flags", {62'd0, o_nan, o_ovf}, 64'd0);
                repeat (3) @(posedge i_clk);
                #1 i_rst_n = 1'b1;
                @(posedge i_clk);
                #1;

                // Single beat, latency to o_valid
                beat(43'sd5, 1'b0, 8'd127, 8'd127, 1'b1, 1'b1, 64'sd327680, 1'b0, 1'b0);
                n = 0;
                do begin
                    @(negedge i_clk);
                    n++;
                end while (!o_valid && n < 20);
                chk("latency", 64'(n), 64'd3);
                drain();

                // Three-beat vector with differing exponents
                beat(43'sd1,  1'b0, 8'd128, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(-43'sd3, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(43'sd8,  1'b0, 8'd125, 8'd127, 1'b1, 1'b1, 64'sd65536, 1'b0, 1'b0);

                // Deep right shift floors
                beat(43'sd1,  1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(-43'sd1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, -64'sd1, 1'b0, 1'b0);

                // NaN via scale, via flag, then clean
                beat(43'sd3,  1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(43'sd7,  1'b0, 8'hFF,  8'd127, 1'b1, 1'b1, 64'sd196608, 1'b1, 1'b0);
                beat(43'sd1,  1'b1, 8'd127, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(43'sd1,  1'b0, 8'd127, 8'd127, 1'b1, 1'b1, 64'sd65536, 1'b1, 1'b0);
                beat(-43'sd2, 1'b0, 8'd127, 8'd127, 1'b1, 1'b1, -64'sd131072, 1'b0, 1'b0);

                // Shift overflow, then sticky cleared
                beat(DP_MAX, 1'b0, 8'd127, 8'd167, 1'b1, 1'b1, ACC_MAX, 1'b0, 1'b1);
                beat(43'sd2, 1'b0, 8'd127, 8'd127, 1'b1, 1'b1, 64'sd131072, 1'b0, 1'b0);

                // Accumulator saturation and exact negative boundary
                beat(DP_MAX, 1'b0, 8'd131, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(DP_MAX, 1'b0, 8'd131, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(DP_MAX, 1'b0, 8'd131, 8'd127, 1'b1, 1'b1, ACC_MAX, 1'b0, 1'b1);
                beat(DP_MIN, 1'b0, 8'd131, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(DP_MIN, 1'b0, 8'd131, 8'd127, 1'b1, 1'b1, ACC_MIN, 1'b0, 1'b0);
                drain();

                // Backpressure over a stream of single-beat vectors
                fork
                    begin
                        for (int v = 1; v <= 6; v++)
                            beat(43'(v), 1'b0, 8'd127, 8'd127, 1'b1, 1'b1,
                                 64'(v) * 64'sd65536, 1'b0, 1'b0);
                    end
                    begin
                        repeat (3) @(posedge i_clk);
                        #1 i_ready = 1'b0;
                        repeat (5) @(posedge i_clk);
                        #1 i_ready = 1'b1;
                    end
                join
                drain();

                // Reset while a result is held and a partial vector is in flight
                i_ready = 1'b0;
                beat(43'sd9, 1'b0, 8'd127, 8'd127, 1'b1, 1'b0, 64'sd0, 1'b0, 1'b0);
                beat(43'sd4, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'sd0, 1'b0, 1'b0);
                repeat (4) @(posedge i_clk);
                #1;
                chk("pre_rst_held", o_acc, 64'sd589824);
                i_rst_n = 1'b0;
                #1;
                chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
                chk("mid_rst_o_acc", o_acc, 64'd0);
                chk("mid_rst_flags", {62'd0, o_nan, o_ovf}, 64'd0);
                @(posedge i_clk);
                #1 i_ready = 1'b1;
                repeat (2) @(posedge i_clk);
                #1 i_rst_n = 1'b1;
                @(posedge i_clk);
                #1;
                beat(43'sd6, 1'b0, 8'd127, 8'd127, 1'b1, 1'b1, 64'sd393216, 1'b0, 1'b0);
                drain();
                repeat (3) @(posedge i_clk);

                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        join_any
    end

endmodule
